// File: rtl/dm_resp_ctrl_pkg.sv
// Shared encodings for the data-memory responder: SaveType codes, FSM states,
// the latched request record and the alignment rule.
package dm_resp_ctrl_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    SAVE_W   = 2'b00,
    SAVE_H   = 2'b01,
    SAVE_B   = 2'b10,
    SAVE_RSV = 2'b11
  } save_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic                       wr;
    save_t                      stype;
    logic [NUM_LANES*LANE_W-1:0] wdata;
  } req_t;

  // Alignment rule shared by loads and stores; the reserved type always errors.
  function automatic logic misaligned(input save_t t, input logic [1:0] off);
    case (t)
      SAVE_W:  return off != 2'b00;
      SAVE_H:  return off[0];
      SAVE_B:  return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Combinational store merge: overlays right-aligned store data onto the old word
// in the lanes selected by type and byte offset, and flags misaligned requests.
module dm_lane_merge
  import dm_resp_ctrl_pkg::*;
(
  input  logic [NUM_LANES*LANE_W-1:0] old_word,
  input  logic [NUM_LANES*LANE_W-1:0] wdata,
  input  save_t                       stype,
  input  logic [1:0]                  off,
  output logic [NUM_LANES*LANE_W-1:0] new_word,
  output logic                        err
);

  assign err = misaligned(stype, off);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    logic              en;
    logic [LANE_W-1:0] src;

    always_comb begin
      en  = 1'b0;
      src = wdata[LANE_W-1:0];
      case (stype)
        SAVE_W: begin
          en  = 1'b1;
          src = wdata[LANE_W*i +: LANE_W];
        end
        SAVE_H: begin
          // halfword occupies the lane pair picked by off[1]
          en  = (LANE[1] == off[1]);
          src = wdata[LANE_W*(i%2) +: LANE_W];
        end
        SAVE_B: begin
          en  = (LANE == off);
          src = wdata[LANE_W-1:0];
        end
        default: en = 1'b0;
      endcase
    end

    assign new_word[LANE_W*i +: LANE_W] = (en && !err) ? src : old_word[LANE_W*i +: LANE_W];
  end

endmodule

// File: rtl/dm_resp_ctrl.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// accesses the word array once, then holds a single response beat until consumed.
module dm_resp_ctrl
  import dm_resp_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_type,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W   = ADDR_W - 2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  req_t              req;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_word;
  logic [31:0]       new_word;
  logic              merr;

  // Upper address bits beyond the array are dropped, so addresses wrap modulo the array size.
  assign idx     = addr[ADDR_W-1:2];
  assign rd_word = mem[idx];

  dm_lane_merge u_merge (
    .old_word (rd_word),
    .wdata    (req.wdata),
    .stype    (req.stype),
    .off      (addr[1:0]),
    .new_word (new_word),
    .err      (merr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req       <= '{wr: req_wr, stype: save_t'(req_type), wdata: req_wdata};
            addr      <= req_addr;
            cnt       <= WAIT_LD;
            req_ready <= 1'b0;
            state     <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          rsp_err   <= merr;
          rsp_rdata <= (!req.wr && !merr) ? rd_word : 32'h0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array has no reset; a reset during ACCESS suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_ACCESS && req.wr && !merr) mem[idx] <= new_word;
  end

endmodule

// File: tb/tb_dm_resp_ctrl.sv
// Bench for dm_resp_ctrl: directed scenarios plus random traffic on a WAIT_CYCLES=2
// instance and a WAIT_CYCLES=0 instance, checked against a byte-array memory model.
module tb_dm_resp_ctrl;

  localparam logic [1:0] T_W = 2'b00, T_H = 2'b01, T_B = 2'b10, T_R = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wr    [2];
  logic [11:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  req_type  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int          lat [2] = '{2, 0};
  logic [7:0]  mb  [2][4096];
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  dm_resp_ctrl #(.ADDR_W(12), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_type(req_type[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dm_resp_ctrl #(.ADDR_W(12), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_type(req_type[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, addresses taken modulo 4 KB.
  task automatic model_exec(input int u, input bit wr, input int addr, input logic [31:0] wd,
                            input logic [1:0] t, output logic [31:0] rd, output logic er);
    int a, base;
    a    = addr % 4096;
    base = a - (a % 4);
    er   = (t == T_R) || (t == T_H && (a % 2) != 0) || (t == T_W && (a % 4) != 0);
    rd   = 32'h0;
    if (!er && wr) begin
      case (t)
        T_W: for (int k = 0; k < 4; k++) mb[u][base+k] = wd[8*k +: 8];
        T_H: begin mb[u][a] = wd[7:0]; mb[u][a+1] = wd[15:8]; end
        default: mb[u][a] = wd[7:0];
      endcase
    end else if (!er) begin
      rd = {mb[u][base+3], mb[u][base+2], mb[u][base+1], mb[u][base]};
    end
  endtask

  // One full transaction; entered and left at a negedge with the unit idle.
  task automatic xact(input int u, input bit wr, input int addr, input logic [31:0] wd,
                      input logic [1:0] t, input int hold, input bit keep_valid);
    logic [31:0] er;
    logic        ee;
    int          n;
    model_exec(u, wr, addr, wd, t, er, ee);
    check1("req_ready_idle", req_ready[u], 1'b1);
    req_valid[u] = 1'b1;
    req_wr[u]    = wr;
    req_addr[u]  = addr[11:0];
    req_wdata[u] = wd;
    req_type[u]  = t;
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) req_valid[u] = 1'b0;
    check1("req_ready_busy", req_ready[u], 1'b0);
    n = 1;
    while (!rsp_valid[u] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check32("latency", 32'(n), 32'(lat[u] + 2));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check1("hold_valid", rsp_valid[u], 1'b1);
      check1("hold_req_ready", req_ready[u], 1'b0);
      check32("hold_rdata", rsp_rdata[u], er);
    end
    check32("rdata", rsp_rdata[u], er);
    check1("err", rsp_err[u], ee);
    rsp_ready[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[u] = 1'b0;
    check1("rsp_drop", rsp_valid[u], 1'b0);
  endtask

  initial begin
    logic acc;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_wr[u] = 1'b0; req_addr[u] = '0;
      req_wdata[u] = '0;   req_type[u] = '0; rsp_ready[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check1("rst_req_ready", req_ready[u], 1'b1);
      check1("rst_rsp_valid", rsp_valid[u], 1'b0);
      check32("rst_rdata", rsp_rdata[u], 32'h0);
      check1("rst_err", rsp_err[u], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Known contents for the region used below
    for (int u = 0; u < 2; u++)
      for (int w = 0; w < 16; w++) xact(u, 1'b1, w * 4, $urandom, T_W, 0, 1'b0);

    // Word store/load and sub-word merges
    xact(0, 1'b1, 32'h004, 32'hDEADBEEF, T_W, 0, 1'b0);
    xact(0, 1'b0, 32'h004, 32'h0,        T_W, 0, 1'b0);
    xact(0, 1'b1, 32'h006, 32'h000000AA, T_B, 0, 1'b0);
    xact(0, 1'b0, 32'h004, 32'h0,        T_W, 0, 1'b0);
    check32("sb_merge", rsp_rdata[0], 32'hDEAABEEF);
    xact(0, 1'b1, 32'h004, 32'h00001234, T_H, 0, 1'b0);
    xact(0, 1'b0, 32'h004, 32'h0,        T_W, 0, 1'b0);
    check32("sh_merge", rsp_rdata[0], 32'hDEAA1234);

    // Error requests leave the array untouched
    xact(0, 1'b1, 32'h005, 32'hFFFFFFFF, T_H, 0, 1'b0);
    xact(0, 1'b1, 32'h00A, 32'hFFFFFFFF, T_W, 0, 1'b0);
    xact(0, 1'b1, 32'h008, 32'hFFFFFFFF, T_R, 0, 1'b0);
    xact(0, 1'b0, 32'h004, 32'h0,        T_W, 0, 1'b0);
    check32("err_unchanged", rsp_rdata[0], 32'hDEAA1234);
    xact(0, 1'b0, 32'h008, 32'h0,        T_W, 0, 1'b0);

    // Backpressure with req_valid held through the busy period
    xact(0, 1'b0, 32'h004, 32'h0, T_W, 5, 1'b1);
    xact(0, 1'b0, 32'h004, 32'h0, T_W, 0, 1'b0);

    // Reset during WAIT of a store
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 12'h010;
    req_wdata[0] = 32'h55555555; req_type[0] = T_W;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check1("mid_busy", req_ready[0], 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check1("mid_rst_ready", req_ready[0], 1'b1);
    acc = 1'b0;
    repeat (5) begin
      @(negedge clk);
      acc = acc | rsp_valid[0];
    end
    check1("mid_rst_no_rsp", acc, 1'b0);
    xact(0, 1'b0, 32'h010, 32'h0, T_W, 0, 1'b0);

    // Zero-wait build and address wrap
    xact(1, 1'b1, 32'h1004, 32'hCAFEF00D, T_W, 0, 1'b0);
    xact(1, 1'b0, 32'h004,  32'h0,        T_W, 0, 1'b0);
    check32("alias", rsp_rdata[1], 32'hCAFEF00D);
    xact(1, 1'b0, 32'h1004, 32'h0,        T_W, 1, 1'b0);

    // Random traffic on both builds
    for (int u = 0; u < 2; u++)
      repeat (60)
        xact(u, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom,
             2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
